// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and codes for the load/store unit.
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic [2:0] WB_ALU = 3'b000;
  localparam logic [2:0] WB_LW  = 3'b001;
  localparam logic [2:0] WB_LB  = 3'b010;
  localparam logic [2:0] WB_LH  = 3'b011;
  localparam logic [2:0] WB_LBU = 3'b100;
  localparam logic [2:0] WB_LHU = 3'b101;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;
  function automatic logic [2:0] wb_code(input logic [2:0] f3);
    return f3 == F3_B ? WB_LB : f3 == F3_H ? WB_LH : f3 == F3_W ? WB_LW :
           f3 == F3_BU ? WB_LBU : f3 == F3_HU ? WB_LHU : WB_ALU;
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte-lane strobes, replicated store data and access legality checks.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        store,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic [3:0]  strb,
  output logic [31:0] wdata_rep,
  output logic        misaligned,
  output logic        illegal
);
  always_comb begin
    illegal    = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) || (store && funct3[2]);
    misaligned = funct3[1:0] == 2'b01 ? off[0] : funct3[1:0] == 2'b10 ? |off : 1'b0;
    strb       = funct3[1:0] == 2'b00 ? 4'b0001 << off : funct3[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
    wdata_rep  = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} : funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
  end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: sequences one load/store on a wait-stated memory port, stalling the PC meanwhile.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ld_data,
  output logic [2:0]  wb_sel,
  output logic        wb_en,
  output logic        fault,
  output logic [1:0]  fault_cause
);
  localparam logic [7:0] TO = TIMEOUT[7:0];
  state_t state, state_n;
  logic [7:0] cnt;
  logic [31:0] addr_q;
  logic st_q;
  logic [2:0] wb_q;
  logic [3:0] strb;
  logic [31:0] wdata_rep;
  logic misaligned, illegal, accept, reject, done, expire;
  lsu_lane_align u_align (
    .funct3(req_funct3),
    .store(req_store),
    .off(req_addr[1:0]),
    .wdata(req_wdata),
    .strb(strb),
    .wdata_rep(wdata_rep),
    .misaligned(misaligned),
    .illegal(illegal)
  );
  always_comb begin
    accept = state == IDLE && req_valid && !misaligned && !illegal;
    reject = state == IDLE && req_valid && (misaligned || illegal);
    done   = state == ACCESS && mem_ready;
    expire = state == ACCESS && !mem_ready && cnt == TO;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // A completed access wins over the timeout when ready arrives on the last allowed cycle
  always_comb begin
    state_n = accept ? ACCESS : done ? RESP : expire ? IDLE : state == RESP ? IDLE : state;
  end
  always_comb begin
    stall   = !rst && (accept || state == ACCESS);
    mem_req = state == ACCESS;
    mem_we  = state == ACCESS && st_q;
    mem_addr = {addr_q[31:2], 2'b00};
    wb_en   = state == RESP && !st_q;
    wb_sel  = wb_en ? wb_q : WB_ALU;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr_q      <= '0;
      st_q        <= 1'b0;
      wb_q        <= WB_ALU;
      mem_wstrb   <= '0;
      mem_wdata   <= '0;
      cnt         <= '0;
      ld_data     <= '0;
      fault       <= 1'b0;
      fault_cause <= CAUSE_NONE;
    end else begin
      if (accept) begin
        addr_q    <= req_addr;
        st_q      <= req_store;
        wb_q      <= wb_code(req_funct3);
        mem_wstrb <= req_store ? strb : 4'b0000;
        mem_wdata <= req_store ? wdata_rep : 32'b0;
      end
      cnt <= accept ? 8'd0 : (state == ACCESS && !mem_ready) ? cnt + 8'd1 : cnt;
      if (done && !st_q) ld_data <= mem_rdata >> {addr_q[1:0], 3'b000};
      fault <= reject || expire;
      if (reject || expire) fault_cause <= expire ? CAUSE_TIMEOUT : illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: randomized scoreboard bench for lsu_ctrl against a byte-level access model.
module tb_lsu_ctrl;
  localparam int TO = 15;
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } acc_t;
  typedef struct {
    logic [2:0]  sel;
    logic [31:0] data;
  } rsp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_store = 1'b0;
  logic [2:0] req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic stall, mem_req, mem_we, wb_en, fault;
  logic [31:0] mem_addr, mem_wdata, ld_data;
  logic [3:0] mem_wstrb;
  logic [2:0] wb_sel;
  logic [1:0] fault_cause;
  int n_chk = 0, n_fail = 0;
  acc_t acc_q[$];
  rsp_t rsp_q[$];
  logic [1:0] flt_q[$];
  logic [2:0] wbtab [0:7] = '{3'b010, 3'b011, 3'b001, 3'b000, 3'b100, 3'b101, 3'b000, 3'b000};

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .ld_data(ld_data), .wb_sel(wb_sel), .wb_en(wb_en),
    .fault(fault), .fault_cause(fault_cause)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void unexp(string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: DUT event with nothing expected at %0t", name, $time);
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents an access, a writeback or a fault
  always @(negedge clk) if (!rst) begin
    if (mem_req && mem_ready) begin
      if (acc_q.size() == 0) unexp("mem_access");
      else begin
        acc_t e;
        e = acc_q.pop_front();
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_we", 32'(mem_we), 32'(e.we));
        if (e.we) begin
          chk("mem_wstrb", 32'(mem_wstrb), 32'(e.strb));
          chk("mem_wdata", mem_wdata, e.wdata);
        end
      end
    end
    if (wb_en) begin
      if (rsp_q.size() == 0) unexp("wb_en");
      else begin
        rsp_t r;
        r = rsp_q.pop_front();
        chk("wb_sel", 32'(wb_sel), 32'(r.sel));
        chk("ld_data", ld_data, r.data);
      end
    end
    if (fault) begin
      if (flt_q.size() == 0) unexp("fault");
      else begin
        logic [1:0] c;
        c = flt_q.pop_front();
        chk("fault_cause", 32'(fault_cause), 32'(c));
      end
    end
  end

  task automatic idle();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int waits, input logic [31:0] rd);
    int nb, o, sc, rc, exp_sc, exp_rc;
    logic legal, misal, fin;
    acc_t e;
    rsp_t r;
    nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    o = int'(a[1:0]);
    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) && !(st && f3[2]);
    misal = (o % nb) != 0;
    if (!legal || misal) begin
      flt_q.push_back(legal ? 2'b01 : 2'b11);
      exp_sc = 0;
      exp_rc = 0;
    end else if (waits > TO) begin
      flt_q.push_back(2'b10);
      exp_sc = TO + 2;
      exp_rc = TO + 1;
    end else begin
      e.addr = a & ~32'h3;
      e.we = st;
      e.strb = '0;
      e.wdata = '0;
      for (int i = 0; i < 4; i++) begin
        e.strb[i] = (i >= o) && (i < o + nb);
        e.wdata[8*i +: 8] = wd[8*(i%nb) +: 8];
      end
      acc_q.push_back(e);
      if (!st) begin
        r.sel = wbtab[f3];
        r.data = rd >> (8 * o);
        rsp_q.push_back(r);
      end
      exp_sc = waits + 2;
      exp_rc = waits + 1;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_store = st;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = wd;
    mem_ready = 1'b0;
    sc = 0;
    rc = 0;
    fin = 1'b0;
    for (int c = 0; c < TO + 8 && !fin; c++) begin
      #1;
      if (stall) sc++;
      if (mem_req) begin
        rc++;
        mem_ready = (rc == waits + 1);
        mem_rdata = mem_ready ? rd : $urandom();
      end
      if (!stall) fin = 1'b1;
      else begin
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        mem_ready = 1'b0;
      end
    end
    chk("op_completed", 32'(fin), 32'd1);
    chk("stall_cycles", 32'(sc), 32'(exp_sc));
    chk("mem_req_cycles", 32'(rc), 32'(exp_rc));
  endtask

  initial begin
    req_valid = 1'b1;
    req_funct3 = 3'b010;
    req_addr = 32'h100;
    #12;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_ld_data", ld_data, 32'd0);
    chk("rst_wb_sel", 32'(wb_sel), 32'd0);
    chk("rst_fault_cause", 32'(fault_cause), 32'd0);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_op(1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    run_op(1'b0, 3'b100, 32'h203, 32'h0, 2, 32'h80AA55CC);
    run_op(1'b1, 3'b001, 32'h302, 32'h1234ABCD, 0, 32'h0);
    run_op(1'b0, 3'b010, 32'h101, 32'h0, 0, 32'h0);
    run_op(1'b1, 3'b100, 32'h104, 32'h55, 0, 32'h0);
    run_op(1'b0, 3'b011, 32'h108, 32'h0, 0, 32'h0);
    run_op(1'b0, 3'b001, 32'h10B, 32'h0, 0, 32'h0);
    run_op(1'b1, 3'b010, 32'h500, 32'hCAFEF00D, TO + 5, 32'h0);
    run_op(1'b0, 3'b001, 32'h602, 32'h0, TO, 32'hBEEF1234);
    run_op(1'b1, 3'b000, 32'h701, 32'h000000A5, 1, 32'h0);
    idle();
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_store = 1'b1;
    req_funct3 = 3'b010;
    req_addr = 32'h400;
    req_wdata = $urandom();
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mem_req_before_rst", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("mem_req_in_rst", 32'(mem_req), 32'd0);
    chk("stall_in_rst", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_op(1'b0, 3'b000, 32'h0, 32'h0, 1, 32'h123456F1);
    for (int k = 0; k < 200; k++) begin
      int w;
      w = ($urandom_range(0, 19) == 0) ? TO + 1 + int'($urandom_range(0, 3)) : int'($urandom_range(0, 4));
      run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(), $urandom(), w, $urandom());
      if ($urandom_range(0, 3) == 0) idle();
    end
    repeat (4) idle();
    chk("acc_q_drained", 32'(acc_q.size()), 32'd0);
    chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    chk("flt_q_drained", 32'(flt_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencing controller for the RISC-V core.
- Takes a decoded load/store (effective address from the ALU, rs2 data, funct3) and runs one access on a wait-stated data-memory port.
- Stalls the PC while the access is outstanding.
- Drives the 3-bit writeback-select code and the lane-aligned load word consumed by the ALU/memory writeback mux.
- Flags misaligned accesses, illegal funct3 and memory timeouts.

## Interface
Parameters:
- `TIMEOUT`, default 15: maximum consecutive `mem_ready`-low cycles in ACCESS before a timeout fault (1..255).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  current instruction is a load or store.
- `req_store`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr`  in  32  effective byte address.
- `req_wdata`  in  32  rs2 store data.
- `stall`  out  1  hold PC/instruction this cycle.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  write enable.
- `mem_addr`  out  32  word-aligned address, `{addr[31:2],2'b00}`.
- `mem_wstrb`  out  4  byte write strobes.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_ready`  in  1  access complete, read data valid.
- `mem_rdata`  in  32  read word.
- `ld_data`  out  32  `mem_rdata >> (8*addr[1:0])`, registered.
- `wb_sel`  out  3  writeback mux select: 000 ALU, 001 LW, 010 LB, 011 LH, 100 LBU, 101 LHU.
- `wb_en`  out  1  one-cycle register-write enable for a completed load.
- `fault`  out  1  one-cycle fault pulse.
- `fault_cause`  out  2  01 misaligned, 10 timeout, 11 illegal funct3; held until the next fault.

## Operation
FSM with three states: IDLE, ACCESS, RESP.

- **IDLE**
  - Legal, aligned `req_valid`:
    - `stall` = 1 combinationally.
    - Latch address, store flag, wb code, strobes and wdata.
    - Next state ACCESS; wait counter cleared.
  - Misaligned request (H with `addr[0]`=1; W with `addr[1:0]`≠0) or illegal funct3 (011, 110, 111, or 100/101 with store):
    - No memory access; `stall` = 0.
    - `fault` pulses in the next cycle with the matching cause.
    - Remain in IDLE.
- **ACCESS**
  - `mem_req` = 1, `stall` = 1.
  - `mem_*` outputs are driven from the latched registers and stay stable until `mem_ready`.
  - `mem_ready` = 1: capture `ld_data` for a load; next state RESP.
  - `mem_ready` = 0: counter increments. When the counter reaches `TIMEOUT`:
    - `mem_req` drops next cycle.
    - `fault` pulses with cause 10.
    - Next state IDLE; `wb_en` is not asserted.
- **RESP**
  - `stall` = 0, so the PC advances at the end of this cycle.
  - Load: `wb_en` = 1 and `wb_sel` = latched code. Store: `wb_en` = 0.
  - `req_valid` is ignored in this state, since it still reflects the same instruction.
  - Next state IDLE.
- **Store lanes** (`o` = `addr[1:0]`):
  - SB: strobe `0001<<o`, data `{4{wdata[7:0]}}`.
  - SH: strobe `0011<<o`, data `{2{wdata[15:0]}}`.
  - SW: strobe `1111`, data `wdata`.
- **Outside RESP-with-load:** `wb_sel` = 000 and `wb_en` = 0.
- **Reset values:**
  - State IDLE.
  - `mem_req`, `mem_we`, `wb_en`, `fault` = 0.
  - `mem_wstrb` = 0; `mem_addr`, `mem_wdata`, `ld_data` = 0.
  - `wb_sel` = 000, `fault_cause` = 00, counter = 0.
  - `stall` = 0 while reset is asserted.

## Timing
- **Zero-wait access:** request seen in cycle T0 (IDLE, stall 1); `mem_req` in T1 with `mem_ready`; RESP in T2 (stall 0, `wb_en`). Total 3 cycles per memory instruction.
- **With N wait cycles:** 3+N cycles.
- **Timeout:** when `mem_ready` stays low, the fault pulse occurs `TIMEOUT`+1 cycles after entering ACCESS.
- **Read data:** `mem_rdata` is sampled only in the `mem_ready` cycle.
- **`mem_ready` outside ACCESS:** ignored.
- **Back-to-back memory instructions:** the next request is accepted in the IDLE cycle immediately after RESP.
- **Reset mid-access:** `mem_req` deasserts asynchronously and the transaction is abandoned with no `wb_en` and no `fault`.

## Structure
- **Package `lsu_pkg`:**
  - State enum (IDLE/ACCESS/RESP).
  - `wb_sel` code constants (WB_ALU…WB_LHU).
  - funct3 constants.
  - Fault-cause constants.
- **Sub-module `lsu_lane_align`:** purely combinational. Computes strobes, replicated wdata and the misaligned/illegal flags from funct3, store flag and `addr[1:0]`. The FSM, counter and output registers stay in `lsu_ctrl`.

## Test plan
- LW at 0x100, `mem_ready` on the first ACCESS cycle, `mem_rdata`=0xDEADBEEF → stall high 2 cycles; RESP has `wb_en`=1, `wb_sel`=001, `ld_data`=0xDEADBEEF.
- LBU at 0x203 with 2 wait cycles, `mem_rdata`=0x80AA55CC → `mem_addr`=0x200; `ld_data`=0x00000080 and `wb_sel`=100 in RESP; 5-cycle total.
- SH at 0x302, wdata=0x1234ABCD → `mem_we`=1, `mem_wstrb`=1100, `mem_wdata`=0xABCDABCD; `wb_en`=0 in RESP.
- LW at 0x101 → no `mem_req`; `fault`=1 next cycle with cause 01; stall never asserted.
- `mem_ready` held low with `TIMEOUT`=15 → `mem_req` held for 16 cycles, then fault cause 10, state returns to IDLE, no `wb_en`.
- `rst` asserted during the 2nd wait cycle of an SW → `mem_req` drops immediately; after release a new LB at 0x0 completes normally with `wb_sel`=010.
